music_box_record_writer: RTL and testbench
==========================================

# music_box_record_writer

Recording-side stage of the music box: while `mainState` selects the record state, captures one 8-bit audio sample per `sample_tick` and writes it, zero-extended, to consecutive SDRAM words through the shared SDRAM command interface. It produces the contiguous sample image that the playback state later reads back from address 0 upward. It reports completion or failure to `MusicBoxStateController` the same way the other state modules do.

## Interface
- `STATE_ID`, 5'd2: `mainState` value that enables this block.
- `SAMPLE_COUNT`, 110250: samples per recording (5 s at 22050 Hz); must be ≥1 and < 2^19.
- `BASE_ADDR`, 25'd0: SDRAM word address of sample 0.
- `ACK_TIMEOUT`, 1024: maximum cycles `sdram_inputValid` may wait for acceptance.
- `clock_50Mhz` in 1: the only clock; every register runs on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mainState` in 5: state from the controller.
- `sample_tick` in 1: single-cycle 22.05 kHz strobe, synchronous to `clock_50Mhz`.
- `sample_in` in 8: unsigned sample, valid while `sample_tick` is high.
- `stateComplete` out 1: high when the recording finished successfully.
- `recordFailed` out 1: high after an overrun or a timeout.
- `samplesWritten` out 19: count of writes the SDRAM accepted.
- `debugString` out 32: {5'd0, state[2:0], 5'd0, samplesWritten}.
- `sdram_inputAddress` out 25: command address.
- `sdram_writeData` out 16: {8'd0, sample}.
- `sdram_isWriting` out 1: 1 while a command is presented.
- `sdram_inputValid` out 1: command request.
- `sdram_recievedCommand` in 1: controller accepted the command this cycle.
- `sdram_isBusy` in 1: controller cannot take a new command.

## Operation
- States:
  - IDLE
  - ARM
  - WAIT_SAMPLE
  - ISSUE
  - WAIT_ACK
  - DONE
  - FAIL
- Reset: all outputs and registers are 0 and the state is IDLE. Reset takes effect immediately, including mid-write.
- Abort: whenever `mainState != STATE_ID`, the next edge forces IDLE and clears all outputs, counters and the pending flag, from any state.
- IDLE → ARM when `mainState == STATE_ID`. Ticks in IDLE and ARM are ignored.
- ARM → WAIT_SAMPLE after one cycle, with index = 0.
- Capture register: one entry. A `sample_tick` in WAIT_SAMPLE, ISSUE or WAIT_ACK loads `sample_in` and sets `pending`.
- Overrun: a tick while `pending` is already set, and not cleared in the same cycle → FAIL.
- WAIT_SAMPLE → ISSUE when `pending` is set. If index == SAMPLE_COUNT, go to DONE instead.
- ISSUE: wait while `sdram_isBusy` is high. When it is low:
  - drive address = BASE_ADDR + index, data = {8'd0, captured}, `isWriting` = 1, `inputValid` = 1;
  - go to WAIT_ACK.
- WAIT_ACK: hold all command outputs stable until `sdram_recievedCommand` is sampled high. On that edge:
  - `inputValid` and `isWriting` drop to 0;
  - index increments, and `samplesWritten` = index + 1;
  - `pending` clears;
  - next state is DONE if the new index == SAMPLE_COUNT, otherwise WAIT_SAMPLE.
- A tick in the same cycle as the acceptance is captured, not an overrun: the slot frees and reloads on the same edge.
- Timeout: if `sdram_recievedCommand` has not arrived after ACK_TIMEOUT cycles in WAIT_ACK → FAIL, with `inputValid` dropped.
- DONE: `stateComplete` = 1 and held. No further commands; ticks are ignored.
- FAIL: `recordFailed` = 1 and held. `stateComplete` = 0 and no commands are issued. Exit only via abort or reset.
- Width rules:
  - index is 19 bits;
  - address = BASE_ADDR + zero-extended index, wrapping modulo 2^25;
  - `samplesWritten` never exceeds SAMPLE_COUNT.

## Timing
- The tick sampled at edge T sets `pending`.
- With `isBusy` low, `inputValid` is high from edge T+2, through WAIT_SAMPLE→ISSUE at T+1 and the command at T+2.
- `recordFailed` rises on the edge after the overrun cycle.
- Acceptance sampled at edge A → `inputValid` is low after A, giving a one-cycle-minimum gap between commands.
- `stateComplete` rises one edge after the final acceptance.
- Worst-case service time: 2 + ACK_TIMEOUT + busy cycles, which must stay under the 2267-cycle tick period.

## Test plan
- Normal run, SAMPLE_COUNT=4, ticks every 2267 cycles with samples 0x10..0x13, ack one cycle after valid → writes at addresses 0..3 with data 0x0010..0x0013; `samplesWritten`=4; `stateComplete`=1 one edge after the 4th ack; no 5th command.
- `isBusy` held high for 100 cycles after a tick → `inputValid` stays low through the busy window, rises the cycle after busy falls, and the address/data are unchanged.
- Two ticks 3 cycles apart while the ack is withheld → `recordFailed`=1 on the following edge; `inputValid` drops; `stateComplete` stays 0.
- Tick in the same cycle as `recievedCommand` → no fail; the next write carries the new sample at index+1.
- Ack withheld for ACK_TIMEOUT cycles → FAIL.
- `mainState` changed away mid-WAIT_ACK → all outputs 0 on the next edge. Returning to STATE_ID → restart at address BASE_ADDR.
- `reset_n` pulsed low asynchronously mid-command → outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/music_box_record_writer.sv
// Record-side stage of the music box: captures one 8-bit sample per tick and
// writes it zero-extended to consecutive SDRAM words, reporting done/failed.
module music_box_record_writer #(
  parameter logic [4:0]  STATE_ID     = 5'd2,
  parameter int          SAMPLE_COUNT = 110250,
  parameter logic [24:0] BASE_ADDR    = 25'd0,
  parameter int          ACK_TIMEOUT  = 1024
) (
  input  logic        clock_50Mhz,
  input  logic        reset_n,
  input  logic [4:0]  mainState,
  input  logic        sample_tick,
  input  logic [7:0]  sample_in,
  output logic        stateComplete,
  output logic        recordFailed,
  output logic [18:0] samplesWritten,
  output logic [31:0] debugString,
  output logic [24:0] sdram_inputAddress,
  output logic [15:0] sdram_writeData,
  output logic        sdram_isWriting,
  output logic        sdram_inputValid,
  input  logic        sdram_recievedCommand,
  input  logic        sdram_isBusy
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ARM         = 3'd1;
  localparam logic [2:0] S_WAIT_SAMPLE = 3'd2;
  localparam logic [2:0] S_ISSUE       = 3'd3;
  localparam logic [2:0] S_WAIT_ACK    = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;
  localparam logic [2:0] S_FAIL        = 3'd6;

  localparam int          TW         = $clog2(ACK_TIMEOUT + 1);
  localparam logic [18:0] LAST_INDEX = 19'(SAMPLE_COUNT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  logic [2:0]    state_q,    state_d;
  logic [18:0]   index_q,    index_d;
  logic [18:0]   written_q,  written_d;
  logic [7:0]    cap_q,      cap_d;
  logic          pending_q,  pending_d;
  logic [24:0]   addr_q,     addr_d;
  logic [15:0]   wdata_q,    wdata_d;
  logic          valid_q,    valid_d;
  logic          writing_q,  writing_d;
  logic          complete_q, complete_d;
  logic          failed_q,   failed_d;
  logic [TW-1:0] timer_q,    timer_d;

  logic        active;
  logic        capturing;
  logic        accept;
  logic        overrun;
  logic [18:0] index_inc;

  assign active    = (mainState == STATE_ID);
  assign capturing = (state_q == S_WAIT_SAMPLE) || (state_q == S_ISSUE) ||
                     (state_q == S_WAIT_ACK);
  assign accept    = (state_q == S_WAIT_ACK) && sdram_recievedCommand;
  // The single capture slot frees on acceptance, so a tick on that same edge reloads it.
  assign overrun   = capturing && sample_tick && pending_q && !accept;
  assign index_inc = index_q + 19'd1;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    written_d  = written_q;
    cap_d      = cap_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    valid_d    = valid_q;
    writing_d  = writing_q;
    complete_d = complete_q;
    failed_d   = failed_q;
    timer_d    = timer_q;

    if (!active) begin
      state_d    = S_IDLE;
      index_d    = '0;
      written_d  = '0;
      cap_d      = '0;
      pending_d  = 1'b0;
      addr_d     = '0;
      wdata_d    = '0;
      valid_d    = 1'b0;
      writing_d  = 1'b0;
      complete_d = 1'b0;
      failed_d   = 1'b0;
      timer_d    = '0;
    end else begin
      if (capturing && sample_tick && !overrun) begin
        cap_d     = sample_in;
        pending_d = 1'b1;
      end else if (accept) begin
        pending_d = 1'b0;
      end

      case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          index_d = '0;
          state_d = S_WAIT_SAMPLE;
        end
        S_WAIT_SAMPLE: begin
          if (index_q == LAST_INDEX) begin
            state_d    = S_DONE;
            complete_d = 1'b1;
          end else if (pending_q) begin
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!sdram_isBusy) begin
            addr_d    = BASE_ADDR + {6'd0, index_q};
            wdata_d   = {8'd0, cap_q};
            valid_d   = 1'b1;
            writing_d = 1'b1;
            timer_d   = '0;
            state_d   = S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (sdram_recievedCommand) begin
            valid_d   = 1'b0;
            writing_d = 1'b0;
            index_d   = index_inc;
            written_d = index_inc;
            if (index_inc == LAST_INDEX) begin
              state_d    = S_DONE;
              complete_d = 1'b1;
            end else begin
              state_d = S_WAIT_SAMPLE;
            end
          end else if (timer_q == TMO_LAST) begin
            state_d   = S_FAIL;
            failed_d  = 1'b1;
            valid_d   = 1'b0;
            writing_d = 1'b0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_DONE: complete_d = 1'b1;
        S_FAIL: failed_d = 1'b1;
        default: state_d = S_IDLE;
      endcase

      if (overrun) begin
        state_d    = S_FAIL;
        failed_d   = 1'b1;
        complete_d = 1'b0;
        valid_d    = 1'b0;
        writing_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      written_q  <= '0;
      cap_q      <= '0;
      pending_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      valid_q    <= 1'b0;
      writing_q  <= 1'b0;
      complete_q <= 1'b0;
      failed_q   <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      written_q  <= written_d;
      cap_q      <= cap_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      writing_q  <= writing_d;
      complete_q <= complete_d;
      failed_q   <= failed_d;
      timer_q    <= timer_d;
    end
  end

  assign stateComplete      = complete_q;
  assign recordFailed       = failed_q;
  assign samplesWritten     = written_q;
  assign debugString        = {5'd0, state_q, 5'd0, written_q};
  assign sdram_inputAddress = addr_q;
  assign sdram_writeData    = wdata_q;
  assign sdram_isWriting    = writing_q;
  assign sdram_inputValid   = valid_q;

endmodule

// File: tb/tb_music_box_record_writer.sv
// Directed bench for music_box_record_writer: cycle table plus hand sequences
// for busy stall, overrun, timeout, abort and asynchronous reset.
module tb_music_box_record_writer;

  localparam int ACK_TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ms;
  logic        tick;
  logic [7:0]  smp;
  logic        recv;
  logic        busy;
  logic        cmp;
  logic        fl;
  logic [18:0] cnt;
  logic [31:0] dbg;
  logic [24:0] addr;
  logic [15:0] data;
  logic        wr;
  logic        vld;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  music_box_record_writer #(
    .STATE_ID(5'd2), .SAMPLE_COUNT(4), .BASE_ADDR(25'd0), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clock_50Mhz(clk), .reset_n(rst_n), .mainState(ms), .sample_tick(tick),
    .sample_in(smp), .stateComplete(cmp), .recordFailed(fl), .samplesWritten(cnt),
    .debugString(dbg), .sdram_inputAddress(addr), .sdram_writeData(data),
    .sdram_isWriting(wr), .sdram_inputValid(vld),
    .sdram_recievedCommand(recv), .sdram_isBusy(busy)
  );

  typedef struct {
    logic [4:0]  ms;
    logic        tick;
    logic [7:0]  smp;
    logic        recv;
    logic        busy;
    logic [2:0]  st;
    logic        vld;
    logic        wr;
    logic [24:0] addr;
    logic [15:0] data;
    logic [18:0] cnt;
    logic        cmp;
    logic        fl;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_tick(input logic [7:0] s);
    tick = 1'b1;
    smp  = s;
    step();
    tick = 1'b0;
  endtask

  task automatic go_idle();
    ms = 5'd0; tick = 1'b0; recv = 1'b0; busy = 1'b0;
    step();
  endtask

  task automatic arm();
    ms = 5'd2;
    step();
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int cyc;

    //               ms    tk    smp    rcv   bsy   st    vld   wr    addr    data       cnt    cmp   fl
    vecs[0] = '{5'd2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 25'd0, 16'h0000, 19'd0, 1'b0, 1'b0};
    vecs[1] = '{5'd2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 25'd0, 16'h0000, 19'd0, 1'b0, 1'b0};
    vecs[2] = '{5'd2, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 25'd0, 16'h0000, 19'd0, 1'b0, 1'b0};
    vecs[3] = '{5'd2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 25'd0, 16'h0000, 19'd0, 1'b0, 1'b0};
    vecs[4] = '{5'd2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 25'd0, 16'h00A5, 19'd0, 1'b0, 1'b0};
    vecs[5] = '{5'd2, 1'b1, 8'h3C, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 25'd0, 16'h0000, 19'd1, 1'b0, 1'b0};
    vecs[6] = '{5'd2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 25'd0, 16'h0000, 19'd1, 1'b0, 1'b0};
    vecs[7] = '{5'd2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 25'd1, 16'h003C, 19'd1, 1'b0, 1'b0};
    vecs[8] = '{5'd2, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 25'd0, 16'h0000, 19'd2, 1'b0, 1'b0};
    vecs[9] = '{5'd2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 25'd0, 16'h0000, 19'd2, 1'b0, 1'b0};

    rst_n = 1'b0; ms = 5'd0; tick = 1'b0; smp = 8'd0; recv = 1'b0; busy = 1'b0;
    step();
    step();
    chk("rst_vld", 32'(vld), 32'(0));
    chk("rst_wr", 32'(wr), 32'(0));
    chk("rst_addr", 32'(addr), 32'(0));
    chk("rst_dbg", dbg, 32'(0));
    chk("rst_cmp", 32'(cmp), 32'(0));
    chk("rst_fl", 32'(fl), 32'(0));
    rst_n = 1'b1;
    step();
    chk("idle_st", 32'(dbg[26:24]), 32'(0));

    // Cycle table: arming, first write, tick coinciding with acceptance.
    for (int i = 0; i < 10; i++) begin
      ms = vecs[i].ms; tick = vecs[i].tick; smp = vecs[i].smp;
      recv = vecs[i].recv; busy = vecs[i].busy;
      step();
      chk($sformatf("row%0d_st", i), 32'(dbg[26:24]), 32'(vecs[i].st));
      chk($sformatf("row%0d_vld", i), 32'(vld), 32'(vecs[i].vld));
      chk($sformatf("row%0d_wr", i), 32'(wr), 32'(vecs[i].wr));
      chk($sformatf("row%0d_cnt", i), 32'(cnt), 32'(vecs[i].cnt));
      chk($sformatf("row%0d_cmp", i), 32'(cmp), 32'(vecs[i].cmp));
      chk($sformatf("row%0d_fl", i), 32'(fl), 32'(vecs[i].fl));
      if (vecs[i].vld) begin
        chk($sformatf("row%0d_addr", i), 32'(addr), 32'(vecs[i].addr));
        chk($sformatf("row%0d_data", i), 32'(data), 32'(vecs[i].data));
      end
    end
    tick = 1'b0; recv = 1'b0;

    // Normal four-sample run at the real tick spacing.
    go_idle();
    chk("abort_cnt", 32'(cnt), 32'(0));
    chk("abort_dbg", dbg, 32'(0));
    arm();
    for (int i = 0; i < 4; i++) begin
      do_tick(8'h10 + 8'(i));
      cyc = 1;
      chk($sformatf("run%0d_lat0", i), 32'(vld), 32'(0));
      step(); cyc++;
      chk($sformatf("run%0d_lat1", i), 32'(vld), 32'(0));
      step(); cyc++;
      chk($sformatf("run%0d_lat2", i), 32'(vld), 32'(1));
      chk($sformatf("run%0d_addr", i), 32'(addr), 32'(i));
      chk($sformatf("run%0d_data", i), 32'(data), 32'(16'h0010 + 16'(i)));
      recv = 1'b1;
      step(); cyc++;
      recv = 1'b0;
      chk($sformatf("run%0d_drop", i), 32'(vld), 32'(0));
      chk($sformatf("run%0d_cnt", i), 32'(cnt), 32'(i + 1));
      chk($sformatf("run%0d_cmp", i), 32'(cmp), 32'(i == 3));
      seen = 1'b0;
      while (cyc < 2267) begin
        step(); cyc++;
        if (vld) seen = 1'b1;
      end
      chk($sformatf("run%0d_spurious", i), 32'(seen), 32'(0));
    end
    do_tick(8'h99);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (vld) seen = 1'b1;
    end
    chk("run_no5th", 32'(seen), 32'(0));
    chk("run_cnt_final", 32'(cnt), 32'(4));
    chk("run_cmp_held", 32'(cmp), 32'(1));
    chk("run_st_done", 32'(dbg[26:24]), 32'(5));

    // Busy stall.
    go_idle();
    arm();
    busy = 1'b1;
    do_tick(8'h77);
    seen = 1'b0;
    for (int k = 0; k < 99; k++) begin
      step();
      if (vld) seen = 1'b1;
    end
    chk("busy_held_low", 32'(seen), 32'(0));
    busy = 1'b0;
    step();
    chk("busy_rise", 32'(vld), 32'(1));
    chk("busy_addr", 32'(addr), 32'(0));
    chk("busy_data", 32'(data), 32'(16'h0077));
    step(); step(); step();
    chk("busy_hold_vld", 32'(vld), 32'(1));
    chk("busy_hold_wr", 32'(wr), 32'(1));
    chk("busy_hold_data", 32'(data), 32'(16'h0077));
    recv = 1'b1;
    step();
    recv = 1'b0;
    chk("busy_cnt", 32'(cnt), 32'(1));

    // Overrun: second tick while the ack is withheld.
    go_idle();
    arm();
    do_tick(8'h21);
    step();
    step();
    chk("ovr_vld", 32'(vld), 32'(1));
    chk("ovr_fl_before", 32'(fl), 32'(0));
    do_tick(8'h22);
    chk("ovr_fl", 32'(fl), 32'(1));
    chk("ovr_vld_drop", 32'(vld), 32'(0));
    chk("ovr_cmp", 32'(cmp), 32'(0));
    chk("ovr_st", 32'(dbg[26:24]), 32'(6));
    recv = 1'b1;
    step();
    recv = 1'b0;
    step();
    chk("ovr_fl_held", 32'(fl), 32'(1));
    chk("ovr_vld_held", 32'(vld), 32'(0));

    // Acknowledge timeout.
    go_idle();
    arm();
    do_tick(8'h55);
    step();
    step();
    chk("tmo_vld", 32'(vld), 32'(1));
    for (int k = 1; k < ACK_TO; k++) step();
    chk("tmo_vld_last", 32'(vld), 32'(1));
    chk("tmo_fl_before", 32'(fl), 32'(0));
    step();
    chk("tmo_fl", 32'(fl), 32'(1));
    chk("tmo_vld_drop", 32'(vld), 32'(0));
    chk("tmo_st", 32'(dbg[26:24]), 32'(6));

    // Abort mid-WAIT_ACK, then restart from the base address.
    go_idle();
    arm();
    do_tick(8'h31);
    step(); step();
    recv = 1'b1;
    step();
    recv = 1'b0;
    chk("abt_cnt1", 32'(cnt), 32'(1));
    do_tick(8'h32);
    step(); step();
    chk("abt_vld", 32'(vld), 32'(1));
    chk("abt_addr1", 32'(addr), 32'(1));
    ms = 5'd7;
    step();
    chk("abt_vld0", 32'(vld), 32'(0));
    chk("abt_wr0", 32'(wr), 32'(0));
    chk("abt_addr0", 32'(addr), 32'(0));
    chk("abt_data0", 32'(data), 32'(0));
    chk("abt_dbg0", dbg, 32'(0));
    arm();
    do_tick(8'h33);
    step(); step();
    chk("rst_vld_re", 32'(vld), 32'(1));
    chk("restart_addr", 32'(addr), 32'(0));
    chk("restart_data", 32'(data), 32'(16'h0033));

    // Asynchronous reset in the middle of a command.
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_vld", 32'(vld), 32'(0));
    chk("areset_wr", 32'(wr), 32'(0));
    chk("areset_addr", 32'(addr), 32'(0));
    chk("areset_data", 32'(data), 32'(0));
    step();
    rst_n = 1'b1;
    #1;
    chk("areset_idle", dbg, 32'(0));
    step();
    chk("areset_arm", 32'(dbg[26:24]), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
